// File: rtl/mem_seq_pkg.sv
// Shared types for the memory access sequencer:
// op codes, sequencer states and write-source selects.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_PUSH  = 3'd2,
    OP_POP   = 3'd3,
    OP_CALL  = 3'd4,
    OP_RET   = 3'd5,
    OP_RTI   = 3'd6,
    OP_INT   = 3'd7
  } mem_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALL_LO,
    S_INT_LO,
    S_INT_FL,
    S_RET_HI,
    S_RTI_LO,
    S_RTI_HI
  } seq_state_e;

  localparam logic [1:0] WSRC_REG   = 2'b00;
  localparam logic [1:0] WSRC_PC_HI = 2'b01;
  localparam logic [1:0] WSRC_PC_LO = 2'b10;
  localparam logic [1:0] WSRC_FLAGS = 2'b11;

endpackage

// File: rtl/memory_access_sequencer_stack_pointer_unit.sv
// Stack pointer register with increment/decrement.
// Exposes sp+1 as the next pop address.
module stack_pointer_unit #(
  parameter int unsigned        ADDR_W  = 16,
  parameter logic [ADDR_W-1:0]  SP_INIT = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_plus1
);

  logic [ADDR_W-1:0] sp_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q <= SP_INIT;
    end else if (inc) begin
      sp_q <= sp_q + ADDR_W'(1);
    end else if (dec) begin
      sp_q <= sp_q - ADDR_W'(1);
    end
  end

  assign sp       = sp_q;
  assign sp_plus1 = sp_q + ADDR_W'(1);

endmodule

// File: rtl/memory_access_sequencer.sv
// Memory-stage control: splits each memory op into
// single-word accesses and owns the stack pointer.
module memory_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 16,
  parameter int unsigned       DATA_W  = 16,
  parameter int unsigned       PC_W    = 2 * DATA_W,
  parameter int unsigned       FLAG_W  = 3,
  parameter logic [ADDR_W-1:0] SP_INIT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [ADDR_W-1:0] ea,
  input  logic [PC_W-1:0]   pc,
  input  logic [FLAG_W-1:0] flags,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              memory_read,
  output logic              memory_write,
  output logic [ADDR_W-1:0] memory_address,
  output logic [1:0]        memory_write_src_select,
  output logic              stall,
  output logic              done,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_out,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic [ADDR_W-1:0] sp
);

  seq_state_e        state, nxt;
  mem_op_e           op;
  logic              sp_inc, sp_dec;
  logic              lo_en, fl_en;
  logic [ADDR_W-1:0] sp_plus1;
  logic [DATA_W-1:0] lo_latch;
  logic [FLAG_W-1:0] fl_latch;

  // pc and flags are held stable by the stall, so
  // only the write-source select leaves this block.
  logic unused_ok;
  assign unused_ok = ^{pc, flags};

  assign op = mem_op_e'(op_code);

  stack_pointer_unit #(
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_sp (
    .clk      (clk),
    .reset    (reset),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .sp       (sp),
    .sp_plus1 (sp_plus1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      lo_latch <= '0;
      fl_latch <= '0;
    end else begin
      state <= nxt;
      if (lo_en) lo_latch <= mem_rdata;
      if (fl_en) fl_latch <= mem_rdata[FLAG_W-1:0];
    end
  end

  always_comb begin
    nxt                     = state;
    memory_read             = 1'b0;
    memory_write            = 1'b0;
    memory_address          = '0;
    memory_write_src_select = WSRC_REG;
    stall                   = 1'b0;
    done                    = 1'b0;
    pc_load                 = 1'b0;
    flags_load              = 1'b0;
    sp_inc                  = 1'b0;
    sp_dec                  = 1'b0;
    lo_en                   = 1'b0;
    fl_en                   = 1'b0;
    if (reset) begin
      unique case (state)
        S_IDLE: begin
          if (op_valid) begin
            unique case (op)
              OP_LOAD: begin
                memory_read    = 1'b1;
                memory_address = ea;
                done           = 1'b1;
              end
              OP_STORE: begin
                memory_write   = 1'b1;
                memory_address = ea;
                done           = 1'b1;
              end
              OP_PUSH: begin
                memory_write   = 1'b1;
                memory_address = sp;
                sp_dec         = 1'b1;
                done           = 1'b1;
              end
              OP_POP: begin
                memory_read    = 1'b1;
                memory_address = sp_plus1;
                sp_inc         = 1'b1;
                done           = 1'b1;
              end
              OP_CALL, OP_INT: begin
                memory_write            = 1'b1;
                memory_address          = sp;
                memory_write_src_select = WSRC_PC_HI;
                sp_dec                  = 1'b1;
                stall                   = 1'b1;
                nxt = (op == OP_CALL) ? S_CALL_LO : S_INT_LO;
              end
              OP_RET: begin
                memory_read    = 1'b1;
                memory_address = sp_plus1;
                sp_inc         = 1'b1;
                lo_en          = 1'b1;
                stall          = 1'b1;
                nxt            = S_RET_HI;
              end
              OP_RTI: begin
                memory_read    = 1'b1;
                memory_address = sp_plus1;
                sp_inc         = 1'b1;
                fl_en          = 1'b1;
                stall          = 1'b1;
                nxt            = S_RTI_LO;
              end
            endcase
          end
        end
        S_CALL_LO, S_INT_LO: begin
          memory_write            = 1'b1;
          memory_address          = sp;
          memory_write_src_select = WSRC_PC_LO;
          sp_dec                  = 1'b1;
          if (state == S_CALL_LO) begin
            done = 1'b1;
            nxt  = S_IDLE;
          end else begin
            stall = 1'b1;
            nxt   = S_INT_FL;
          end
        end
        S_INT_FL: begin
          memory_write            = 1'b1;
          memory_address          = sp;
          memory_write_src_select = WSRC_FLAGS;
          sp_dec                  = 1'b1;
          done                    = 1'b1;
          nxt                     = S_IDLE;
        end
        S_RTI_LO: begin
          memory_read    = 1'b1;
          memory_address = sp_plus1;
          sp_inc         = 1'b1;
          lo_en          = 1'b1;
          stall          = 1'b1;
          nxt            = S_RTI_HI;
        end
        S_RET_HI, S_RTI_HI: begin
          memory_read    = 1'b1;
          memory_address = sp_plus1;
          sp_inc         = 1'b1;
          pc_load        = 1'b1;
          flags_load     = (state == S_RTI_HI);
          done           = 1'b1;
          nxt            = S_IDLE;
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  assign pc_out    = pc_load ? {mem_rdata, lo_latch} : '0;
  assign flags_out = flags_load ? fl_latch : '0;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Directed bench for memory_access_sequencer:
// per-cycle vector table plus reset/wrap sequences.
module tb_memory_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [15:0] ea;
  logic [31:0] pc;
  logic [2:0]  flags;
  logic [15:0] mem_rdata;
  logic        memory_read, memory_write;
  logic [15:0] memory_address;
  logic [1:0]  memory_write_src_select;
  logic        stall, done, pc_load, flags_load;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;
  logic [15:0] sp;

  logic [15:0] reg_data = 16'hC0DE;
  logic [15:0] mem [65536];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  memory_access_sequencer dut (
    .clk                     (clk),
    .reset                   (reset),
    .op_valid                (op_valid),
    .op_code                 (op_code),
    .ea                      (ea),
    .pc                      (pc),
    .flags                   (flags),
    .mem_rdata               (mem_rdata),
    .memory_read             (memory_read),
    .memory_write            (memory_write),
    .memory_address          (memory_address),
    .memory_write_src_select (memory_write_src_select),
    .stall                   (stall),
    .done                    (done),
    .pc_load                 (pc_load),
    .pc_out                  (pc_out),
    .flags_load              (flags_load),
    .flags_out               (flags_out),
    .sp                      (sp)
  );

  // Word memory: combinational read, write on the clock edge
  assign mem_rdata = mem[memory_address];

  always @(posedge clk) begin
    if (memory_write) begin
      case (memory_write_src_select)
        2'b00:   mem[memory_address] <= reg_data;
        2'b01:   mem[memory_address] <= pc[31:16];
        2'b10:   mem[memory_address] <= pc[15:0];
        default: mem[memory_address] <= {13'd0, flags};
      endcase
    end
  end

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [15:0] ea;
    logic [31:0] pc;
    logic [2:0]  fl;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  src;
    logic        stall;
    logic        done;
    logic        pl;
    logic [31:0] pco;
    logic        fll;
    logic [2:0]  flo;
    logic [15:0] sp;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(
    logic v, logic [2:0] op, logic [15:0] ea,
    logic [31:0] pcv, logic [2:0] fl,
    logic rd, logic wr, logic [15:0] addr,
    logic [1:0] src, logic stl, logic dn,
    logic pl, logic [31:0] pco, logic fll,
    logic [2:0] flo, logic [15:0] spv);
    vec_t t;
    t.v = v; t.op = op; t.ea = ea; t.pc = pcv;
    t.fl = fl; t.rd = rd; t.wr = wr;
    t.addr = addr; t.src = src; t.stall = stl;
    t.done = dn; t.pl = pl; t.pco = pco;
    t.fll = fll; t.flo = flo; t.sp = spv;
    return t;
  endfunction

  task automatic chk(string nm, int idx,
                     logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %h, want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic chk_idle(string nm, logic [15:0] exp_sp);
    chk({nm, " rd"},    0, 32'(memory_read), 0);
    chk({nm, " wr"},    0, 32'(memory_write), 0);
    chk({nm, " addr"},  0, 32'(memory_address), 0);
    chk({nm, " src"},   0, 32'(memory_write_src_select), 0);
    chk({nm, " stall"}, 0, 32'(stall), 0);
    chk({nm, " done"},  0, 32'(done), 0);
    chk({nm, " pl"},    0, 32'(pc_load), 0);
    chk({nm, " fll"},   0, 32'(flags_load), 0);
    chk({nm, " sp"},    0, 32'(sp), 32'(exp_sp));
  endtask

  task automatic drive(logic v, logic [2:0] op,
                       logic [15:0] e, logic [31:0] p,
                       logic [2:0] f);
    op_valid = v; op_code = op; ea = e; pc = p; flags = f;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 16'h0000;
    reset = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 32'h0, 3'd0);

    // Held in reset: even a valid op must not strobe
    repeat (2) @(negedge clk);
    drive(1'b1, 3'd4, 16'h0, 32'h1111_2222, 3'd0);
    #1 chk_idle("in_reset", 16'hFFFF);

    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 32'h0, 3'd0);
    #1 chk_idle("post_reset", 16'hFFFF);

    // Move sp, start an INT, then drop reset in INT_LO
    @(negedge clk);
    drive(1'b1, 3'd2, 16'h0, 32'h0, 3'd0);
    @(negedge clk);
    drive(1'b1, 3'd7, 16'h0, 32'h1234_5678, 3'd3);
    #1 chk("int_start stall", 0, 32'(stall), 1);
    chk("int_start addr", 0, 32'(memory_address), 32'hFFFE);
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 32'h1234_5678, 3'd3);
    #1 chk("int_lo src", 0, 32'(memory_write_src_select), 2);
    reset = 1'b0;
    #1 chk_idle("mid_int_reset", 16'hFFFF);
    @(negedge clk);
    reset = 1'b1;
    #1 chk_idle("after_mid_reset", 16'hFFFF);

    //      v  op   ea       pc            fl    rd wr addr     src stl dn pl pco           fll flo   sp
    vecs.push_back(mk(1, 3'd1, 16'h0014, 32'h0, 3'd0, 0, 1, 16'h0014, 0, 0, 1, 0, 32'h0, 0, 3'd0, 16'hFFFF));
    vecs.push_back(mk(1, 3'd0, 16'h0014, 32'h0, 3'd0, 1, 0, 16'h0014, 0, 0, 1, 0, 32'h0, 0, 3'd0, 16'hFFFF));
    vecs.push_back(mk(1, 3'd4, 16'h0, 32'hDCBAABCD, 3'd0, 0, 1, 16'hFFFF, 1, 1, 0, 0, 32'h0, 0, 3'd0, 16'hFFFF));
    vecs.push_back(mk(1, 3'd2, 16'h0, 32'hDCBAABCD, 3'd0, 0, 1, 16'hFFFE, 2, 0, 1, 0, 32'h0, 0, 3'd0, 16'hFFFE));
    vecs.push_back(mk(1, 3'd5, 16'h0, 32'h0, 3'd0, 1, 0, 16'hFFFE, 0, 1, 0, 0, 32'h0, 0, 3'd0, 16'hFFFD));
    vecs.push_back(mk(0, 3'd0, 16'h0, 32'h0, 3'd0, 1, 0, 16'hFFFF, 0, 0, 1, 1, 32'hDCBAABCD, 0, 3'd0, 16'hFFFE));
    vecs.push_back(mk(0, 3'd0, 16'h0, 32'h0, 3'd0, 0, 0, 16'h0000, 0, 0, 0, 0, 32'h0, 0, 3'd0, 16'hFFFF));
    vecs.push_back(mk(1, 3'd7, 16'h0, 32'h00010020, 3'd5, 0, 1, 16'hFFFF, 1, 1, 0, 0, 32'h0, 0, 3'd0, 16'hFFFF));
    vecs.push_back(mk(0, 3'd0, 16'h0, 32'h00010020, 3'd5, 0, 1, 16'hFFFE, 2, 1, 0, 0, 32'h0, 0, 3'd0, 16'hFFFE));
    vecs.push_back(mk(0, 3'd0, 16'h0, 32'h00010020, 3'd5, 0, 1, 16'hFFFD, 3, 0, 1, 0, 32'h0, 0, 3'd0, 16'hFFFD));
    vecs.push_back(mk(1, 3'd6, 16'h0, 32'h0, 3'd0, 1, 0, 16'hFFFD, 0, 1, 0, 0, 32'h0, 0, 3'd0, 16'hFFFC));
    vecs.push_back(mk(1, 3'd0, 16'h0, 32'h0, 3'd0, 1, 0, 16'hFFFE, 0, 1, 0, 0, 32'h0, 0, 3'd0, 16'hFFFD));
    vecs.push_back(mk(0, 3'd0, 16'h0, 32'h0, 3'd0, 1, 0, 16'hFFFF, 0, 0, 1, 1, 32'h00010020, 1, 3'd5, 16'hFFFE));
    vecs.push_back(mk(1, 3'd3, 16'h0, 32'h0, 3'd0, 1, 0, 16'h0000, 0, 0, 1, 0, 32'h0, 0, 3'd0, 16'hFFFF));
    vecs.push_back(mk(0, 3'd0, 16'h0, 32'h0, 3'd0, 0, 0, 16'h0000, 0, 0, 0, 0, 32'h0, 0, 3'd0, 16'h0000));
    vecs.push_back(mk(1, 3'd2, 16'h0, 32'h0, 3'd0, 0, 1, 16'h0000, 0, 0, 1, 0, 32'h0, 0, 3'd0, 16'h0000));
    vecs.push_back(mk(0, 3'd0, 16'h0, 32'h0, 3'd0, 0, 0, 16'h0000, 0, 0, 0, 0, 32'h0, 0, 3'd0, 16'hFFFF));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].op, vecs[i].ea,
            vecs[i].pc, vecs[i].fl);
      #1;
      chk("rd",    i, 32'(memory_read), 32'(vecs[i].rd));
      chk("wr",    i, 32'(memory_write), 32'(vecs[i].wr));
      chk("addr",  i, 32'(memory_address), 32'(vecs[i].addr));
      chk("src",   i, 32'(memory_write_src_select), 32'(vecs[i].src));
      chk("stall", i, 32'(stall), 32'(vecs[i].stall));
      chk("done",  i, 32'(done), 32'(vecs[i].done));
      chk("pl",    i, 32'(pc_load), 32'(vecs[i].pl));
      chk("pc_out", i, pc_out, vecs[i].pco);
      chk("fll",   i, 32'(flags_load), 32'(vecs[i].fll));
      chk("fl_out", i, 32'(flags_out), 32'(vecs[i].flo));
      chk("sp",    i, 32'(sp), 32'(vecs[i].sp));
      chk("rw_excl", i, 32'(memory_read & memory_write), 0);
    end

    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 32'h0, 3'd0);
    #1 chk_idle("final_idle", 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
